// File: rtl/pipeline_run_sequencer_if.sv
// Run-control bundle between pipeline_run_sequencer (master) and the cores/monitors (slave).
// Carries restart/halt requests in and load/reset/run status out.
interface pipeline_run_sequencer_if #(
  parameter int NUM_CORES = 1,
  parameter int CNT_W     = 16
);
  logic                 start;
  logic [NUM_CORES-1:0] halt;
  logic                 mem_init_n;
  logic [NUM_CORES-1:0] cpu_rst_n;
  logic                 running;
  logic                 done;
  logic                 timeout;
  logic [NUM_CORES-1:0] halted_mask;
  logic [CNT_W-1:0]     cycle_count;

  modport master (
    input  start, halt,
    output mem_init_n, cpu_rst_n, running, done, timeout, halted_mask, cycle_count
  );

  modport slave (
    output start, halt,
    input  mem_init_n, cpu_rst_n, running, done, timeout, halted_mask, cycle_count
  );
endinterface

// File: rtl/pipeline_run_sequencer.sv
// Run-control sequencer: memory load, settle, staggered per-core reset release, bounded run.
// Optional macro SEQ_RESTART_EN: start in DONE re-enters LOAD; otherwise DONE is terminal.
//
// state    | meaning
// LOAD     | mem_init_n low, memories accept preload, cores held in reset
// SETTLE   | memories loaded, cores still held in reset
// CORE_RST | cores released one by one as the phase counter hits each threshold
// RUN      | cores executing, halts accumulated, run cycles counted
// DONE     | run finished, status frozen for inspection
module pipeline_run_sequencer #(
  parameter int NUM_CORES      = 1,
  parameter int LOAD_CYCLES    = 6,
  parameter int SETTLE_CYCLES  = 10,
  parameter int CPU_RST_CYCLES = 9,
  parameter int STAGGER        = 0,
  parameter int RUN_CYCLES     = 50,
  parameter int CNT_W          = 16
) (
  input  logic SysCLK,
  input  logic SysRST,
  pipeline_run_sequencer_if.master bus
);

  localparam int LOAD_N    = (LOAD_CYCLES    < 1) ? 1 : LOAD_CYCLES;
  localparam int SETTLE_N  = (SETTLE_CYCLES  < 1) ? 1 : SETTLE_CYCLES;
  localparam int CPU_RST_N = (CPU_RST_CYCLES < 1) ? 1 : CPU_RST_CYCLES;
  localparam int RUN_N     = (RUN_CYCLES     < 1) ? 1 : RUN_CYCLES;

  localparam logic [CNT_W-1:0] LOAD_END   = CNT_W'(LOAD_N);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_N);
  localparam logic [CNT_W-1:0] RUN_END    = CNT_W'(RUN_N);

  typedef enum logic [2:0] {
    S_LOAD     = 3'd0,
    S_SETTLE   = 3'd1,
    S_CORE_RST = 3'd2,
    S_RUN      = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     phase_q, phase_d;
  logic                 mem_init_q, mem_init_d;
  logic [NUM_CORES-1:0] cpu_rst_q, cpu_rst_d;
  logic                 running_q, running_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic [CNT_W-1:0]     phase_inc;
  logic [CNT_W-1:0]     count_inc;
  logic [NUM_CORES-1:0] halt_acc;
  logic [CNT_W-1:0]     rel_at [NUM_CORES];

  // Core k leaves reset when the CORE_RST phase counter reaches this value.
  for (genvar k = 0; k < NUM_CORES; k++) begin : g_rel
    assign rel_at[k] = CNT_W'(CPU_RST_N + k * STAGGER);
  end

  assign phase_inc = phase_q + CNT_W'(1);
  assign count_inc = count_q + CNT_W'(1);
  assign halt_acc  = mask_q | bus.halt;

  always_ff @(posedge SysCLK or negedge SysRST) begin
    if (!SysRST) begin
      state_q    <= S_LOAD;
      phase_q    <= '0;
      mem_init_q <= 1'b0;
      cpu_rst_q  <= '0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      mask_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      mem_init_q <= mem_init_d;
      cpu_rst_q  <= cpu_rst_d;
      running_q  <= running_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      mask_q     <= mask_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_inc;
    mem_init_d = mem_init_q;
    cpu_rst_d  = cpu_rst_q;
    running_d  = running_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    mask_d     = mask_q;
    count_d    = count_q;

    unique case (state_q)
      S_LOAD: begin
        if (phase_inc == LOAD_END) begin
          state_d    = S_SETTLE;
          phase_d    = '0;
          mem_init_d = 1'b1;
        end
      end

      S_SETTLE: begin
        if (phase_inc == SETTLE_END) begin
          state_d = S_CORE_RST;
          phase_d = '0;
        end
      end

      S_CORE_RST: begin
        for (int k = 0; k < NUM_CORES; k++) begin
          if (phase_inc == rel_at[k]) cpu_rst_d[k] = 1'b1;
        end
        // The last core has the largest threshold, so its release ends the phase.
        if (phase_inc == rel_at[NUM_CORES-1]) begin
          state_d   = S_RUN;
          phase_d   = '0;
          cpu_rst_d = '1;
          running_d = 1'b1;
        end
      end

      S_RUN: begin
        phase_d = '0;
        count_d = count_inc;
        mask_d  = halt_acc;
        if (&halt_acc) begin
          state_d   = S_DONE;
          running_d = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b0;
        end else if (count_inc == RUN_END) begin
          state_d   = S_DONE;
          running_d = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end

      S_DONE: begin
        phase_d = '0;
`ifdef SEQ_RESTART_EN
        if (bus.start) begin
          state_d    = S_LOAD;
          mem_init_d = 1'b0;
          cpu_rst_d  = '0;
          running_d  = 1'b0;
          done_d     = 1'b0;
          timeout_d  = 1'b0;
          mask_d     = '0;
          count_d    = '0;
        end
`endif
      end

      default: begin
        state_d = S_LOAD;
        phase_d = '0;
      end
    endcase
  end

`ifndef SEQ_RESTART_EN
  logic unused_start;
  assign unused_start = bus.start;
`endif

  assign bus.mem_init_n  = mem_init_q;
  assign bus.cpu_rst_n   = cpu_rst_q;
  assign bus.running     = running_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
  assign bus.halted_mask = mask_q;
  assign bus.cycle_count = count_q;

endmodule
